// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between the fetch stage (read-only)
// and the memory stage (load/store). One transaction is in flight at a time.
// A timeout bounds the wait for bus_ack and completes the request with an error.
module bus_arbiter #(
    parameter int TIMEOUT      = 16,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_fetch_req,
    input  logic [31:0] i_fetch_addr,
    output logic        o_fetch_ready,
    output logic [31:0] o_fetch_rdata,
    output logic        o_fetch_error,
    output logic        o_fetch_busy,
    input  logic        i_data_req,
    input  logic        i_data_we,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    input  logic [3:0]  i_data_wstrb,
    output logic        o_data_ready,
    output logic [31:0] o_data_rdata,
    output logic        o_data_error,
    output logic        o_data_busy,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wstrb,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    // state    | meaning
    // ---------+-----------------------------------------------------------
    // IDLE     | no transaction; arbitrate and latch the winner's payload
    // GRANT_F  | fetch read on the bus; wait for ack or timeout
    // GRANT_D  | data load/store on the bus; wait for ack or timeout
    // RESP     | one-cycle ready pulse to the requester just served
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_F = 2'd1,
        S_GRANT_D = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = $clog2(MAX_DATA_RUN + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_DATA_RUN);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [RW-1:0] r_run_cnt;
    logic          r_resp_fetch;
    logic          r_err;
    logic [31:0]   r_fetch_rdata;
    logic [31:0]   r_data_rdata;
    logic          r_bus_we;
    logic [31:0]   r_bus_addr;
    logic [31:0]   r_bus_wdata;
    logic [3:0]    r_bus_wstrb;

    logic          w_in_grant;
    logic          w_timeout;
    logic          w_pick_fetch;
    logic          w_pick_data;

    assign w_in_grant   = (r_state == S_GRANT_F) || (r_state == S_GRANT_D);
    assign w_timeout    = w_in_grant && (r_timer == TMO_LAST);
    // Data wins ties until it has starved fetch for MAX_DATA_RUN grants.
    assign w_pick_fetch = i_fetch_req && (!i_data_req || (r_run_cnt == RUN_MAX));
    assign w_pick_data  = i_data_req && !w_pick_fetch;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; bus_ack is only honoured while a grant is active
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pick_fetch) begin
                    w_state_nxt = S_GRANT_F;
                end else if (w_pick_data) begin
                    w_state_nxt = S_GRANT_D;
                end
            end
            S_GRANT_F, S_GRANT_D: begin
                if (i_bus_ack || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        o_bus_req     = 1'b0;
        o_fetch_ready = 1'b0;
        o_data_ready  = 1'b0;
        case (r_state)
            S_GRANT_F, S_GRANT_D: o_bus_req = 1'b1;
            S_RESP: begin
                o_fetch_ready = r_resp_fetch;
                o_data_ready  = !r_resp_fetch;
            end
            default: ;
        endcase
    end

    // Grant payload capture, wait timer, starvation counter and response latch
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_timer       <= '0;
            r_run_cnt     <= '0;
            r_resp_fetch  <= 1'b0;
            r_err         <= 1'b0;
            r_fetch_rdata <= '0;
            r_data_rdata  <= '0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_bus_wstrb   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (!i_fetch_req) begin
                        r_run_cnt <= '0;
                    end
                    if (w_pick_fetch) begin
                        r_run_cnt    <= '0;
                        r_resp_fetch <= 1'b1;
                        r_bus_we     <= 1'b0;
                        r_bus_addr   <= i_fetch_addr;
                        r_bus_wdata  <= '0;
                        r_bus_wstrb  <= '0;
                    end else if (w_pick_data) begin
                        if (i_fetch_req && (r_run_cnt != RUN_MAX)) begin
                            r_run_cnt <= r_run_cnt + RW'(1);
                        end
                        r_resp_fetch <= 1'b0;
                        r_bus_we     <= i_data_we;
                        r_bus_addr   <= i_data_addr;
                        r_bus_wdata  <= i_data_wdata;
                        r_bus_wstrb  <= i_data_wstrb;
                    end
                end
                S_GRANT_F, S_GRANT_D: begin
                    r_timer <= r_timer + TW'(1);
                    // An ack on the timeout cycle still counts as a good completion.
                    if (i_bus_ack) begin
                        r_err <= 1'b0;
                        if (r_state == S_GRANT_F) begin
                            r_fetch_rdata <= i_bus_rdata;
                        end else begin
                            r_data_rdata <= r_bus_we ? 32'd0 : i_bus_rdata;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (r_state == S_GRANT_F) begin
                            r_fetch_rdata <= '0;
                        end else begin
                            r_data_rdata <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_fetch_rdata = r_fetch_rdata;
    assign o_data_rdata  = r_data_rdata;
    assign o_fetch_error = o_fetch_ready && r_err;
    assign o_data_error  = o_data_ready && r_err;
    assign o_fetch_busy  = i_fetch_req && !o_fetch_ready;
    assign o_data_busy   = i_data_req && !o_data_ready;
    assign o_bus_we      = r_bus_we;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_wdata   = r_bus_wdata;
    assign o_bus_wstrb   = r_bus_wstrb;

endmodule
